// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control signal bundle between the datapath and hazard_ctrl.
// The perf-counter outputs exist only when HAZ_PERF_CNT_EN is defined.
interface hazard_ctrl_if;
    logic [3:0]  id_opcode;
    logic [3:0]  id_rs;
    logic [3:0]  id_rt;
    logic        ex_memread;
    logic [3:0]  ex_rd;
    logic        ex_redirect;
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    modport master (
        output id_opcode, id_rs, id_rt, ex_memread, ex_rd, ex_redirect,
        input  pc_we, ifid_we, ifid_flush, idex_flush, halted
`ifdef HAZ_PERF_CNT_EN
        , input stall_cnt, flush_cnt
`endif
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, ex_memread, ex_rd, ex_redirect,
        output pc_we, ifid_we, ifid_flush, idex_flush, halted
`ifdef HAZ_PERF_CNT_EN
        , output stall_cnt, flush_cnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush and HLT drain/halt.
// Define HAZ_PERF_CNT_EN to add saturating stall/flush event counters.
//
//   state | meaning
//   RUN   | normal issue; handles redirect, load-use stall and HLT detection
//   DRAIN | HLT moving toward WB; front end frozen, bubbles into EX
//   HALT  | processor halted; left only by reset
module hazard_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hif
);
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } stateT;

    localparam logic [3:0] OP_SW  = 4'h9;
    localparam logic [3:0] OP_LLB = 4'hA;
    localparam logic [3:0] OP_LHB = 4'hB;
    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;
    localparam logic [3:0] OP_HLT = 4'hF;

    stateT      state, stateNext;
    logic [1:0] drainCnt, drainCntNext;
    logic       haltedQ;
    logic       rsRead, usesRt, loadUse;
    logic       pcWe, ifidWe, ifidFlush, idexFlush;

    always_comb begin
        usesRt = (hif.id_opcode[3] == 1'b0) || (hif.id_opcode == OP_SW);
        rsRead = !((hif.id_opcode == OP_LLB) || (hif.id_opcode == OP_LHB) ||
                   (hif.id_opcode == OP_B)   || (hif.id_opcode == OP_JAL) ||
                   (hif.id_opcode == OP_HLT));
        loadUse = hif.ex_memread && (hif.ex_rd != 4'd0) &&
                  ((rsRead && (hif.ex_rd == hif.id_rs)) ||
                   (usesRt && (hif.ex_rd == hif.id_rt)));
    end

    always_comb begin
        stateNext    = state;
        drainCntNext = drainCnt;
        pcWe         = 1'b1;
        ifidWe       = 1'b1;
        ifidFlush    = 1'b0;
        idexFlush    = 1'b0;
        case (state)
            RUN: begin
                if (hif.ex_redirect) begin
                    ifidFlush = 1'b1;
                    idexFlush = 1'b1;
                end else if (loadUse) begin
                    pcWe      = 1'b0;
                    ifidWe    = 1'b0;
                    idexFlush = 1'b1;
                end else if (hif.id_opcode == OP_HLT) begin
                    // HLT itself moves into EX; fetch stops behind it
                    pcWe         = 1'b0;
                    ifidWe       = 1'b0;
                    stateNext    = DRAIN;
                    drainCntNext = 2'd3;
                end
            end
            DRAIN: begin
                pcWe         = 1'b0;
                ifidWe       = 1'b0;
                idexFlush    = 1'b1;
                drainCntNext = drainCnt - 2'd1;
                if (drainCnt == 2'd1) begin
                    stateNext = HALT;
                end
            end
            HALT: begin
                pcWe      = 1'b0;
                ifidWe    = 1'b0;
                idexFlush = 1'b1;
            end
            default: begin
                stateNext    = RUN;
                drainCntNext = 2'd0;
            end
        endcase
        // Hold the pipeline frozen with NOPs for as long as reset is applied
        if (!rst_n) begin
            pcWe      = 1'b0;
            ifidWe    = 1'b0;
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drainCnt <= 2'd0;
            haltedQ  <= 1'b0;
        end else begin
            state    <= stateNext;
            drainCnt <= drainCntNext;
            haltedQ  <= (stateNext == HALT);
        end
    end

    assign hif.pc_we      = pcWe;
    assign hif.ifid_we    = ifidWe;
    assign hif.ifid_flush = ifidFlush;
    assign hif.idex_flush = idexFlush;
    assign hif.halted     = haltedQ;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stallCnt, flushCnt;
    logic        stallEvt, flushEvt;

    assign stallEvt = (state == RUN) && !hif.ex_redirect && loadUse;
    assign flushEvt = (state == RUN) && hif.ex_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt <= 16'd0;
            flushCnt <= 16'd0;
        end else begin
            if (stallEvt && (stallCnt != 16'hFFFF)) begin
                stallCnt <= stallCnt + 16'd1;
            end
            if (flushEvt && (flushCnt != 16'hFFFF)) begin
                flushCnt <= flushCnt + 16'd1;
            end
        end
    end

    assign hif.stall_cnt = stallCnt;
    assign hif.flush_cnt = flushCnt;
`endif
endmodule
